// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Sequences a byte-wide synchronous RAM for instruction fetch and
//            load/store requesters, assembling little-endian words.
// Revision : 1.0
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rollback_in,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [1:0]            lsu_size,
    input  logic [31:0]           lsu_addr,
    input  logic [31:0]           lsu_wdata,
    output logic                  lsu_done,
    output logic [31:0]           lsu_rdata,
    output logic                  ram_en,
    output logic                  ram_r_nw,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_owner_if;
    logic                  r_last_if;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [2:0]            r_len;
    logic [2:0]            r_cnt;
    logic [31:0]           r_wdata;
    logic [31:0]           r_buf;
    logic [31:0]           r_if_hold;
    logic [31:0]           r_lsu_rdata;
    logic                  r_if_done;
    logic                  r_lsu_done;
    logic                  r_ram_en;
    logic                  r_ram_r_nw;
    logic [ADDR_WIDTH-1:0] r_ram_a;
    logic [7:0]            r_ram_dout;

    logic                  w_if_v;
    logic                  w_grant_if;
    logic                  w_accept;
    logic                  w_abort;
    logic [2:0]            w_len;
    logic [2:0]            w_cnt_inc;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [ADDR_WIDTH-1:0] w_next_a;
    logic [4:0]            w_cap_sh;
    logic [31:0]           w_cap_word;
    logic                  w_unused;

    assign w_if_v     = if_req & ~rollback_in;
    assign w_grant_if = w_if_v & (~lsu_req | ~r_last_if);
    assign w_accept   = w_if_v | lsu_req;
    assign w_len      = (w_grant_if || lsu_size[1]) ? 3'd4 : (lsu_size[0] ? 3'd2 : 3'd1);
    assign w_req_addr = w_grant_if ? if_addr[ADDR_WIDTH-1:0] : lsu_addr[ADDR_WIDTH-1:0];
    assign w_abort    = r_owner_if & rollback_in & ((r_state == S_READ) || (r_state == S_DONE));
    assign w_cnt_inc  = r_cnt + 3'd1;
    assign w_next_a   = r_base + {{(ADDR_WIDTH-3){1'b0}}, w_cnt_inc};
    // Byte cnt-1 lands at lane (cnt-1) mod 4; for cnt==4 the lane wraps to 3.
    assign w_cap_sh   = {r_cnt[1:0] - 2'd1, 3'b000};
    assign w_cap_word = r_buf | ({24'd0, ram_din} << w_cap_sh);
    assign w_unused   = ^{if_addr[31:ADDR_WIDTH], lsu_addr[31:ADDR_WIDTH], r_wdata[7:0]};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_grant_if || !lsu_we) ? S_READ : S_WRITE;
                end
            end
            S_READ: begin
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == r_len) begin
                    w_next_state = S_DONE;
                end
            end
            S_WRITE: begin
                if (w_cnt_inc == r_len) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_owner_if  <= 1'b0;
            r_last_if   <= 1'b1;
            r_base      <= '0;
            r_len       <= 3'd0;
            r_cnt       <= 3'd0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_if_hold   <= 32'd0;
            r_lsu_rdata <= 32'd0;
            r_if_done   <= 1'b0;
            r_lsu_done  <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_r_nw  <= 1'b1;
            r_ram_a     <= '0;
            r_ram_dout  <= 8'd0;
        end else begin
            r_if_done  <= 1'b0;
            r_lsu_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner_if <= w_grant_if;
                        r_base     <= w_req_addr;
                        r_len      <= w_len;
                        r_wdata    <= lsu_wdata;
                        r_cnt      <= 3'd0;
                        r_buf      <= 32'd0;
                        r_ram_en   <= 1'b1;
                        r_ram_r_nw <= w_grant_if | ~lsu_we;
                        r_ram_a    <= w_req_addr;
                        if (!w_grant_if && lsu_we) begin
                            r_ram_dout <= lsu_wdata[7:0];
                        end
                    end
                end
                S_READ: begin
                    if (w_abort) begin
                        r_ram_en <= 1'b0;
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_buf <= w_cap_word;
                        end
                        if (r_cnt == r_len) begin
                            if (r_owner_if) begin
                                r_if_done <= 1'b1;
                            end else begin
                                r_lsu_done  <= 1'b1;
                                r_lsu_rdata <= w_cap_word;
                            end
                        end else begin
                            r_cnt    <= w_cnt_inc;
                            r_ram_en <= (w_cnt_inc < r_len);
                            r_ram_a  <= w_next_a;
                        end
                    end
                end
                S_WRITE: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        r_ram_en   <= 1'b0;
                        r_ram_r_nw <= 1'b1;
                        r_lsu_done <= 1'b1;
                    end else begin
                        r_ram_a    <= w_next_a;
                        r_ram_dout <= r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
                    end
                end
                S_DONE: begin
                    r_last_if <= r_owner_if;
                    if (r_owner_if && !rollback_in) begin
                        r_if_hold <= r_buf;
                    end
                end
                default: ;
            endcase
        end
    end

    // A fetch word is exposed only once its DONE cycle survives a flush.
    assign if_done   = r_if_done & ~rollback_in;
    assign if_data   = r_if_done ? r_buf : r_if_hold;
    assign lsu_done  = r_lsu_done;
    assign lsu_rdata = r_lsu_rdata;
    assign ram_en    = r_ram_en;
    assign ram_r_nw  = r_ram_r_nw;
    assign ram_a     = r_ram_a;
    assign ram_dout  = r_ram_dout;

endmodule
`default_nettype wire
